tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): WORD_SIZE, 32, response word width; SIZE_WORD, 3, byte-count width; N_REQ, 3, number of requesters; ACK_TIMEOUT, 15, max cycles waiting for sender busy to rise.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  N_REQ  per-requester word offered.
- req_data  in  N_REQ*WORD_SIZE  packed words; requester i at [i*WORD_SIZE +: WORD_SIZE].
- req_size  in  N_REQ*SIZE_WORD  packed byte counts.
- req_busy  out  N_REQ  requester slot full; offer ignored.
- busy_sender_data  in  1  UART sender busy.
- send_data_register  out  WORD_SIZE  word to sender.
- size_line  out  SIZE_WORD  byte count to sender.
- valid_data  out  1  one-cycle issue strobe.
- grant_id  out  2  requester currently owning the sender.
- clr_err  in  1  clears timeout_err.
- timeout_err  out  1  sticky sender-no-response flag.

Function
REQ-003 Each requester SHALL have a one-entry holding slot; req_valid[i] with req_busy[i]=0 loads it at the clock edge, and req_busy[i] SHALL be 1 from the next cycle until the slot is granted.
REQ-004 An offer with req_size=0 SHALL be accepted and discarded; the slot remains empty.
REQ-005 Offers with req_size>4 SHALL be stored with size clamped to 4.
REQ-006 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-007 IDLE: if any slot full and busy_sender_data=0, select a winner round-robin starting at last_grant+1 (mod N_REQ), latch its word, size and grant_id, then go to ISSUE.
REQ-008 ISSUE: valid_data=1 for exactly one cycle, send_data_register/size_line driven from the latched winner; the winner's slot SHALL be freed in this cycle (req_busy low next cycle); go to WAIT_BUSY.
REQ-009 WAIT_BUSY: on busy_sender_data=1 go to WAIT_DONE; if ACK_TIMEOUT cycles elapse without it, set timeout_err and return to IDLE.
REQ-010 WAIT_DONE: on busy_sender_data=0 update last_grant to grant_id and return to IDLE.
REQ-011 After a timeout, last_grant SHALL also update, so a stuck sender cannot starve others.
REQ-012 send_data_register, size_line and grant_id SHALL hold their values outside ISSUE until the next grant.
REQ-013 A new offer from the requester being granted in ISSUE SHALL be accepted the cycle after ISSUE at the earliest.
REQ-014 If clr_err and a timeout occur in the same cycle, timeout_err SHALL be 1 (set wins).
REQ-015 Minimum spacing between valid_data pulses SHALL be 4 cycles.

Reset
REQ-016 On rst=0 (asynchronous): FSM=IDLE, all slots empty, req_busy=0, valid_data=0, send_data_register=0, size_line=4, grant_id=0, last_grant=N_REQ-1 (requester 0 wins first), timeout_err=0, timeout counter=0.
REQ-017 Reset mid-transfer SHALL drop all held words without issuing any valid_data after release.

Structure
REQ-018 The shared controller package SHALL hold WORD_SIZE, SIZE_WORD, the state encoding, and the ASCII response constants ("BSY\r", "OK\r\n").
REQ-019 The round-robin selector SHALL be a sub-module rr_select (request vector and last_grant in, one-hot grant and index out, combinational).

Verification
REQ-020 Single: requester 1 offers 0x0D0A4B4F, size 4 -> valid_data pulse with that word and grant_id=1; req_busy[1] high until ISSUE.
REQ-021 Contention: all three slots full at once, sender responds with 3 busy cycles each time -> issue order 0,1,2; a re-offer by 0 during 1's transfer is issued after 2.
REQ-022 Timeout: sender never asserts busy -> timeout_err=1 after 15 WAIT_BUSY cycles, FSM back to IDLE, next requester granted; clr_err clears the flag.
REQ-023 Size rules: size 0 -> no issue, req_busy stays 0; size 7 -> size_line=4.
REQ-024 Reset: rst=0 asserted during WAIT_DONE -> all outputs at reset values immediately, no valid_data after release.

Source files
------------

// File: rtl/tx_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// tx_arbiter_pkg
// Shared definitions for the UART transmit controller: default word and
// byte-count widths, the maximum byte count per word, the arbiter FSM state
// encoding and the ASCII response words that requesters send to the host.
// ----------------------------------------------------------------------------
package tx_arbiter_pkg;

    // Default width of one response word, in bits.
    localparam int unsigned WORD_SIZE = 32;

    // Default width of the byte-count field that goes with each word.
    localparam int unsigned SIZE_WORD = 3;

    // A word holds at most four bytes. Larger counts are clamped to this.
    localparam int unsigned MAX_BYTES = 4;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    // ASCII response words. The first character sits in the most
    // significant byte.
    localparam logic [31:0] RSP_BSY = 32'h4253_590D;   // "BSY\r"
    localparam logic [31:0] RSP_OK  = 32'h4F4B_0D0A;   // "OK\r\n"

endpackage : tx_arbiter_pkg

// File: rtl/tx_arbiter_rr_select.sv
// ----------------------------------------------------------------------------
// rr_select
// Combinational round-robin selector. The search starts at last_grant+1
// (mod N_REQ) and wraps around, so the most recent winner has the lowest
// priority. When no request is set, gnt and idx are both zero.
//
// Ports
//   req        in   N_REQ  request vector (one bit per requester)
//   last_grant in   2      index of the previous winner
//   gnt        out  N_REQ  one-hot grant
//   idx        out  2      index of the granted requester
// ----------------------------------------------------------------------------
module rr_select #(
    parameter int unsigned N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last_grant,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       idx
);

    int unsigned cand;
    logic        found;

    // Go through the requesters in priority order and take the first one
    // that has a request. Each candidate is compared against the inner loop
    // index, so every bit select uses a constant index once the loops unroll.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(last_grant) + k) % N_REQ;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!found && (i == cand) && req[i]) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = 2'(i);
                end
            end
        end
    end

endmodule : rr_select

// File: rtl/tx_arbiter.sv
// ----------------------------------------------------------------------------
// tx_arbiter
// Arbitrates up to N_REQ requesters for one UART sender. Each requester has a
// one-entry holding slot. Full slots are granted round-robin. The winner's
// word is offered to the sender with a one-cycle valid_data strobe. The
// arbiter then waits for the sender to raise busy and drop it again. If busy
// does not rise within ACK_TIMEOUT cycles, the sticky timeout_err flag is set
// and arbitration continues with the next requester.
//
// Ports
//   clk                 in   1                 rising-edge clock
//   rst                 in   1                 asynchronous reset, active low
//   req_valid           in   N_REQ             per-requester word offered
//   req_data            in   N_REQ*WORD_SIZE   packed words, i at [i*WORD_SIZE +: WORD_SIZE]
//   req_size            in   N_REQ*SIZE_WORD   packed byte counts
//   req_busy            out  N_REQ             slot full, offer ignored
//   busy_sender_data    in   1                 UART sender busy
//   send_data_register  out  WORD_SIZE         word to sender
//   size_line           out  SIZE_WORD         byte count to sender
//   valid_data          out  1                 one-cycle issue strobe
//   grant_id            out  2                 requester owning the sender
//   clr_err             in   1                 clears timeout_err
//   timeout_err         out  1                 sticky sender-no-response flag
// ----------------------------------------------------------------------------
module tx_arbiter #(
    parameter int unsigned WORD_SIZE   = tx_arbiter_pkg::WORD_SIZE,
    parameter int unsigned SIZE_WORD   = tx_arbiter_pkg::SIZE_WORD,
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WORD_SIZE-1:0] req_data,
    input  logic [N_REQ*SIZE_WORD-1:0] req_size,
    output logic [N_REQ-1:0]           req_busy,
    input  logic                       busy_sender_data,
    output logic [WORD_SIZE-1:0]       send_data_register,
    output logic [SIZE_WORD-1:0]       size_line,
    output logic                       valid_data,
    output logic [1:0]                 grant_id,
    input  logic                       clr_err,
    output logic                       timeout_err
);

    import tx_arbiter_pkg::*;

    localparam int unsigned          CNT_W      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [SIZE_WORD-1:0] SIZE_MAX   = SIZE_WORD'(MAX_BYTES);
    localparam logic [1:0]           LAST_RESET = 2'(N_REQ - 1);
    localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(ACK_TIMEOUT - 1);

    tx_state_t            state;
    tx_state_t            state_next;

    logic [N_REQ-1:0]     slot_full;
    logic [WORD_SIZE-1:0] slot_data [N_REQ];
    logic [SIZE_WORD-1:0] slot_size [N_REQ];

    logic [1:0]           last_grant;
    logic [CNT_W-1:0]     wait_cnt;
    logic [CNT_W-1:0]     wait_cnt_next;

    logic [N_REQ-1:0]     rr_gnt;
    logic [1:0]           rr_idx;
    logic [WORD_SIZE-1:0] win_data;
    logic [SIZE_WORD-1:0] win_size;

    logic                 grant_load;    // IDLE -> ISSUE: latch the winner
    logic                 xfer_close;    // transfer finished or timed out
    logic                 timeout_hit;

    // ------------------------------------------------------------------
    // Round-robin winner among the full slots
    // ------------------------------------------------------------------
    rr_select #(
        .N_REQ (N_REQ)
    ) u_rr_select (
        .req        (slot_full),
        .last_grant (last_grant),
        .gnt        (rr_gnt),
        .idx        (rr_idx)
    );

    // Select the winner's word and size with an AND-OR mux on the one-hot
    // grant. This never indexes past N_REQ.
    always_comb begin
        win_data = '0;
        win_size = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rr_gnt[i]) begin
                win_data = win_data | slot_data[i];
                win_size = win_size | slot_size[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        grant_load    = 1'b0;
        xfer_close    = 1'b0;
        timeout_hit   = 1'b0;
        case (state)
            IDLE: begin
                if ((|slot_full) && !busy_sender_data) begin
                    grant_load = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_next = '0;
                state_next    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_sender_data) begin
                    wait_cnt_next = '0;
                    state_next    = WAIT_DONE;
                end else if (wait_cnt == CNT_LAST) begin
                    wait_cnt_next = '0;
                    timeout_hit   = 1'b1;
                    xfer_close    = 1'b1;
                    state_next    = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!busy_sender_data) begin
                    xfer_close = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign valid_data = (state == ISSUE);
    assign req_busy   = slot_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Holding slots
    // The granted slot is freed at the end of ISSUE. It still reads as full
    // during ISSUE, so a new offer from the winner lands one cycle later at
    // the earliest. An offer with a zero byte count is consumed without
    // marking the slot full.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_full <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                slot_data[i] <= '0;
                slot_size[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (slot_full[i]) begin
                    if ((state == ISSUE) && (grant_id == 2'(i))) begin
                        slot_full[i] <= 1'b0;
                    end
                end else if (req_valid[i]) begin
                    slot_data[i] <= req_data[i*WORD_SIZE +: WORD_SIZE];
                    if (req_size[i*SIZE_WORD +: SIZE_WORD] > SIZE_MAX) begin
                        slot_size[i] <= SIZE_MAX;
                    end else begin
                        slot_size[i] <= req_size[i*SIZE_WORD +: SIZE_WORD];
                    end
                    slot_full[i] <= (req_size[i*SIZE_WORD +: SIZE_WORD] != '0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sender-facing registers. They change only when a new winner is
    // latched and hold their value between grants.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            send_data_register <= '0;
            size_line          <= SIZE_MAX;
            grant_id           <= '0;
        end else if (grant_load) begin
            send_data_register <= win_data;
            size_line          <= win_size;
            grant_id           <= rr_idx;
        end
    end

    // last_grant also advances on a timeout, so a stuck sender rotates
    // through the requesters instead of retrying one requester forever.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= LAST_RESET;
        end else if (xfer_close) begin
            last_grant <= grant_id;
        end
    end

    // Sticky error flag. A timeout in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end else if (clr_err) begin
            timeout_err <= 1'b0;
        end
    end

endmodule : tx_arbiter

// File: tb/tb_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tx_arbiter
// Directed self-checking bench for tx_arbiter. Inputs change and outputs are
// sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_tx_arbiter;

    localparam int unsigned WS = 32;
    localparam int unsigned SW = 3;
    localparam int unsigned NR = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*WS-1:0]  req_data;
    logic [NR*SW-1:0]  req_size;
    logic [NR-1:0]     req_busy;
    logic              busy_sender_data;
    logic [WS-1:0]     send_data_register;
    logic [SW-1:0]     size_line;
    logic              valid_data;
    logic [1:0]        grant_id;
    logic              clr_err;
    logic              timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    tx_arbiter #(
        .WORD_SIZE   (WS),
        .SIZE_WORD   (SW),
        .N_REQ       (NR),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_data           (req_data),
        .req_size           (req_size),
        .req_busy           (req_busy),
        .busy_sender_data   (busy_sender_data),
        .send_data_register (send_data_register),
        .size_line          (size_line),
        .valid_data         (valid_data),
        .grant_id           (grant_id),
        .clr_err            (clr_err),
        .timeout_err        (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic offer(input int unsigned id, input logic [WS-1:0] d, input logic [SW-1:0] s);
        req_valid[id]         = 1'b1;
        req_data[id*WS +: WS] = d;
        req_size[id*SW +: SW] = s;
    endtask

    task automatic do_reset();
        rst              = 1'b0;
        req_valid        = '0;
        req_data         = '0;
        req_size         = '0;
        busy_sender_data = 1'b0;
        clr_err          = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Waits at most 40 cycles for a valid_data strobe and returns the values
    // the DUT shows in that cycle.
    task automatic wait_issue(output bit seen, output logic [1:0] id,
                              output logic [WS-1:0] d, output logic [SW-1:0] s,
                              output int at);
        seen = 1'b0; id = '0; d = '0; s = '0; at = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (valid_data === 1'b1) begin
                seen = 1'b1;
                id   = grant_id;
                d    = send_data_register;
                s    = size_line;
                at   = cyc;
            end
        end
    endtask

    // Call in the ISSUE cycle. Raises sender busy for n cycles from the next
    // cycle, then drops it.
    task automatic sender_ack(input int n);
        @(negedge clk);
        busy_sender_data = 1'b1;
        repeat (n) @(negedge clk);
        busy_sender_data = 1'b0;
    endtask

    task automatic test_reset();
        rst              = 1'b0;
        req_valid        = '0;
        req_data         = '0;
        req_size         = '0;
        busy_sender_data = 1'b0;
        clr_err          = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({valid_data, req_busy, grant_id, timeout_err} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: valid=%b busy=%b grant=%0d err=%b want all 0",
                     valid_data, req_busy, grant_id, timeout_err);
        end
        tests_run++;
        if (send_data_register !== 32'h0 || size_line !== 3'd4) begin
            tests_failed++;
            $display("FAIL reset_data: data=%h size=%0d want 0 and 4", send_data_register, size_line);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit seen; logic [1:0] id; logic [WS-1:0] d; logic [SW-1:0] s; int at;
        do_reset();
        offer(1, 32'h0D0A4B4F, 3'd4);
        @(negedge clk);
        req_valid = '0;
        tests_run++;
        if (req_busy !== 3'b010) begin
            tests_failed++; $display("FAIL single_busy_load: got %b want 010", req_busy);
        end
        wait_issue(seen, id, d, s, at);
        tests_run++;
        if (!seen || id !== 2'd1 || d !== 32'h0D0A4B4F || s !== 3'd4) begin
            tests_failed++;
            $display("FAIL single_issue: seen=%b id=%0d data=%h size=%0d want 1,1,0d0a4b4f,4", seen, id, d, s);
        end
        tests_run++;
        if (req_busy !== 3'b010) begin
            tests_failed++; $display("FAIL single_busy_issue: got %b want 010", req_busy);
        end
        @(negedge clk);
        tests_run++;
        if (valid_data !== 1'b0 || req_busy !== 3'b000) begin
            tests_failed++;
            $display("FAIL single_after_issue: valid=%b busy=%b want 0 000", valid_data, req_busy);
        end
        busy_sender_data = 1'b1;
        repeat (3) @(negedge clk);
        busy_sender_data = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (send_data_register !== 32'h0D0A4B4F || grant_id !== 2'd1 || valid_data !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_hold: data=%h grant=%0d valid=%b want 0d0a4b4f 1 0",
                     send_data_register, grant_id, valid_data);
        end
    endtask

    task automatic test_contention();
        bit seen; logic [1:0] id; logic [WS-1:0] d; logic [SW-1:0] s; int at; int prev;
        logic [1:0]    exp_id   [4];
        logic [WS-1:0] exp_data [4];
        logic [SW-1:0] exp_size [4];
        exp_id[0] = 2'd0; exp_data[0] = 32'hA000_0000; exp_size[0] = 3'd1;
        exp_id[1] = 2'd1; exp_data[1] = 32'hA111_1111; exp_size[1] = 3'd2;
        exp_id[2] = 2'd2; exp_data[2] = 32'hA222_2222; exp_size[2] = 3'd3;
        exp_id[3] = 2'd0; exp_data[3] = 32'hB000_0000; exp_size[3] = 3'd2;
        do_reset();
        for (int unsigned r = 0; r < 3; r++) offer(r, exp_data[r], exp_size[r]);
        @(negedge clk);
        req_valid = '0;
        tests_run++;
        if (req_busy !== 3'b111) begin
            tests_failed++; $display("FAIL cont_busy_all: got %b want 111", req_busy);
        end
        prev = -100;
        for (int k = 0; k < 4; k++) begin
            wait_issue(seen, id, d, s, at);
            tests_run++;
            if (!seen || id !== exp_id[k] || d !== exp_data[k] || s !== exp_size[k]) begin
                tests_failed++;
                $display("FAIL cont_issue%0d: seen=%b id=%0d data=%h size=%0d want id=%0d data=%h size=%0d",
                         k, seen, id, d, s, exp_id[k], exp_data[k], exp_size[k]);
            end
            if (k > 0) begin
                tests_run++;
                if (at - prev < 4) begin
                    tests_failed++; $display("FAIL cont_spacing%0d: gap=%0d want >=4", k, at - prev);
                end
            end
            prev = at;
            if (k == 1) begin
                // Requester 0 offers again while requester 1 is being issued.
                offer(0, exp_data[3], exp_size[3]);
                @(negedge clk);
                req_valid        = '0;
                busy_sender_data = 1'b1;
                tests_run++;
                if (req_busy !== 3'b101) begin
                    tests_failed++; $display("FAIL cont_reoffer_busy: got %b want 101", req_busy);
                end
                repeat (3) @(negedge clk);
                busy_sender_data = 1'b0;
            end else begin
                sender_ack(3);
            end
        end
    endtask

    task automatic test_timeout();
        bit seen; logic [1:0] id; logic [WS-1:0] d; logic [SW-1:0] s; int at; int nvalid;
        do_reset();
        offer(0, 32'hC000_0000, 3'd2);
        offer(1, 32'hC111_1111, 3'd3);
        @(negedge clk);
        req_valid = '0;
        wait_issue(seen, id, d, s, at);
        tests_run++;
        if (!seen || id !== 2'd0) begin
            tests_failed++; $display("FAIL to_first: seen=%b id=%0d want 1 0", seen, id);
        end
        repeat (15) @(negedge clk);
        tests_run++;
        if (timeout_err !== 1'b0) begin
            tests_failed++; $display("FAIL to_early: err=%b want 0 after 15 waits", timeout_err);
        end
        @(negedge clk);
        tests_run++;
        if (timeout_err !== 1'b1 || valid_data !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_set: err=%b valid=%b want 1 0", timeout_err, valid_data);
        end
        wait_issue(seen, id, d, s, at);
        tests_run++;
        if (!seen || id !== 2'd1 || d !== 32'hC111_1111 || timeout_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL to_next: seen=%b id=%0d data=%h err=%b want 1 1 c1111111 1", seen, id, d, timeout_err);
        end
        clr_err = 1'b1;
        @(negedge clk);
        tests_run++;
        if (timeout_err !== 1'b0) begin
            tests_failed++; $display("FAIL to_clear: err=%b want 0", timeout_err);
        end
        repeat (15) @(negedge clk);
        tests_run++;
        if (timeout_err !== 1'b1) begin
            tests_failed++; $display("FAIL to_set_wins: err=%b want 1", timeout_err);
        end
        @(negedge clk);
        clr_err = 1'b0;
        tests_run++;
        if (timeout_err !== 1'b0) begin
            tests_failed++; $display("FAIL to_clear2: err=%b want 0", timeout_err);
        end
        nvalid = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid_data === 1'b1) nvalid++;
        end
        tests_run++;
        if (nvalid != 0) begin
            tests_failed++; $display("FAIL to_idle: got %0d issues want 0", nvalid);
        end
    endtask

    task automatic test_size();
        bit seen; logic [1:0] id; logic [WS-1:0] d; logic [SW-1:0] s; int at; int nvalid;
        do_reset();
        offer(0, 32'hDEAD_BEEF, 3'd0);
        @(negedge clk);
        req_valid = '0;
        tests_run++;
        if (req_busy !== 3'b000) begin
            tests_failed++; $display("FAIL size0_busy: got %b want 000", req_busy);
        end
        nvalid = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid_data === 1'b1) nvalid++;
        end
        tests_run++;
        if (nvalid != 0) begin
            tests_failed++; $display("FAIL size0_issue: got %0d issues want 0", nvalid);
        end
        offer(2, 32'h1234_5678, 3'd7);
        @(negedge clk);
        req_valid = '0;
        wait_issue(seen, id, d, s, at);
        tests_run++;
        if (!seen || id !== 2'd2 || d !== 32'h1234_5678 || s !== 3'd4) begin
            tests_failed++;
            $display("FAIL size7_clamp: seen=%b id=%0d data=%h size=%0d want 1 2 12345678 4", seen, id, d, s);
        end
        sender_ack(2);
        @(negedge clk);
    endtask

    task automatic test_reset_midxfer();
        bit seen; logic [1:0] id; logic [WS-1:0] d; logic [SW-1:0] s; int at; int nvalid;
        do_reset();
        offer(1, 32'h5555_AAAA, 3'd4);
        @(negedge clk);
        req_valid = '0;
        wait_issue(seen, id, d, s, at);
        @(negedge clk);
        busy_sender_data = 1'b1;
        offer(0, 32'h0101_0101, 3'd1);
        offer(2, 32'h0202_0202, 3'd1);
        @(negedge clk);
        req_valid = '0;
        tests_run++;
        if (!seen || req_busy !== 3'b101) begin
            tests_failed++; $display("FAIL rstx_setup: seen=%b busy=%b want 1 101", seen, req_busy);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({valid_data, req_busy, grant_id, timeout_err} !== 7'b0 ||
            send_data_register !== 32'h0 || size_line !== 3'd4) begin
            tests_failed++;
            $display("FAIL rstx_async: valid=%b busy=%b grant=%0d err=%b data=%h size=%0d want 0 000 0 0 0 4",
                     valid_data, req_busy, grant_id, timeout_err, send_data_register, size_line);
        end
        @(negedge clk);
        rst              = 1'b1;
        busy_sender_data = 1'b0;
        nvalid = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid_data === 1'b1) nvalid++;
        end
        tests_run++;
        if (nvalid != 0 || req_busy !== 3'b000) begin
            tests_failed++;
            $display("FAIL rstx_release: got %0d issues busy=%b want 0 000", nvalid, req_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_size();
        test_reset_midxfer();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_tx_arbiter
